// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// master = loader side, slave = byte source / program memory side.
interface program_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Streaming program loader: fills program memory from a length-prefixed byte stream, then
// releases cpu_reset. Define LOADER_CHECKSUM_EN to require a trailing zero-sum checksum byte.
module program_loader #(
    parameter int unsigned MEMORY_DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    program_loader_if.master bus,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             error
);
    localparam int unsigned IdxW = $clog2(MEMORY_DEPTH) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StDone,
        StErr
`ifdef LOADER_CHECKSUM_EN
        , StChk
`endif
    } stateT;

    stateT           state;
    logic [IdxW-1:0] lenWords;
    logic [IdxW-1:0] wordIdx;
    logic [IdxW-1:0] nextIdx;
    logic [1:0]      byteCnt;
    logic [23:0]     asmWord;
    logic            accept;

    // rx_ready is registered, so accept never feeds an output combinationally.
    assign accept  = bus.rx_valid && bus.rx_ready;
    assign nextIdx = wordIdx + 1'b1;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] byteSum;
    logic [7:0] chkSum;
    assign chkSum = byteSum + bus.rx_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= StIdle;
            lenWords      <= '0;
            wordIdx       <= '0;
            byteCnt       <= '0;
            asmWord       <= '0;
            bus.rx_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_reset     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            byteSum       <= '0;
`endif
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state        <= StLen;
                        bus.rx_ready <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        cpu_reset    <= 1'b1;
                    end
                end
                StLen: begin
                    if (accept) begin
                        if (bus.rx_data == 8'd0 || {24'd0, bus.rx_data} > MEMORY_DEPTH) begin
                            state        <= StErr;
                            bus.rx_ready <= 1'b0;
                            busy         <= 1'b0;
                            error        <= 1'b1;
                        end else begin
                            state    <= StData;
                            lenWords <= IdxW'(bus.rx_data);
                            wordIdx  <= '0;
                            byteCnt  <= '0;
                        end
`ifdef LOADER_CHECKSUM_EN
                        byteSum <= bus.rx_data;
`endif
                    end
                end
                StData: begin
                    if (accept) begin
                        asmWord <= {asmWord[15:0], bus.rx_data};
                        byteCnt <= byteCnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        byteSum <= chkSum;
`endif
                        if (byteCnt == 2'd3) begin
                            state         <= StWrite;
                            bus.rx_ready  <= 1'b0;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= {{(30 - IdxW){1'b0}}, wordIdx, 2'b00};
                            bus.mem_wdata <= {asmWord, bus.rx_data};
                        end
                    end
                end
                StWrite: begin
                    wordIdx <= nextIdx;
                    if (nextIdx < lenWords) begin
                        state        <= StData;
                        bus.rx_ready <= 1'b1;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state        <= StChk;
                        bus.rx_ready <= 1'b1;
`else
                        state     <= StDone;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                StChk: begin
                    if (accept) begin
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        if (chkSum == 8'd0) begin
                            state     <= StDone;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= StErr;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end
endmodule
